// File: rtl/logic_anlz.sv
// rtl/logic_anlz.sv - logic analyzer: AXI-lite registers, masked run-length sampler, 64-deep AXIS FIFO
// Optional: define LA_OVERFLOW_MARKER_EN to insert a zero-count marker word after FIFO drops.
module logic_anlz #(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     axis_clk,
  input  logic                     axis_rst_n,
  output logic                     user_clock2,
  output logic                     uck2_rst_n,
  input  logic                     axi_awvalid,
  input  logic [pADDR_WIDTH-1:0]   axi_awaddr,
  output logic                     axi_awready,
  input  logic                     axi_wvalid,
  input  logic [pDATA_WIDTH-1:0]   axi_wdata,
  input  logic [pDATA_WIDTH/8-1:0] axi_wstrb,
  output logic                     axi_wready,
  input  logic                     axi_arvalid,
  input  logic [pADDR_WIDTH-1:0]   axi_araddr,
  output logic                     axi_arready,
  output logic                     axi_rvalid,
  output logic [pDATA_WIDTH-1:0]   axi_rdata,
  input  logic                     axi_rready,
  input  logic                     cc_la_enable,
  input  logic [23:0]              up_la_data,
  output logic [pDATA_WIDTH-1:0]   m_tdata,
  output logic [pDATA_WIDTH/8-1:0] m_tstrb,
  output logic [pDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  output logic [1:0]               m_tuser,
  input  logic                     m_tready,
  output logic                     la_hpri_req
);

  localparam logic [pADDR_WIDTH-1:0] A_MASK = pADDR_WIDTH'(32'h1000);
  localparam logic [pADDR_WIDTH-1:0] A_HTH  = pADDR_WIDTH'(32'h1004);
  localparam logic [pADDR_WIDTH-1:0] A_LTH  = pADDR_WIDTH'(32'h1008);
  localparam logic [pADDR_WIDTH-1:0] A_POP  = pADDR_WIDTH'(32'h100C);
  localparam logic [pADDR_WIDTH-1:0] A_EN   = pADDR_WIDTH'(32'h1010);

  logic [23:0] la_mask;
  logic [6:0]  h_thresh, l_thresh, pop_cond;
  logic        la_en;
  logic        wr_fire, rd_fire, flush;
  logic [pDATA_WIDTH-1:0] rd_val;

  logic        s_vld, run_act, extend, close;
  logic [23:0] s_val, run_val;
  logic [7:0]  run_cnt;

  logic [31:0] mem [64];
  logic [5:0]  wr_ptr, rd_ptr;
  logic [6:0]  level, level_nxt, free;
  logic [1:0]  n_wr;
  logic [31:0] w0, w1;
  logic        pop, stream_nxt;
`ifdef LA_OVERFLOW_MARKER_EN
  logic        ovf, ovf_nxt;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, axis_clk, axis_rst_n, axi_wstrb, axi_wdata[pDATA_WIDTH-1:24]};

  assign user_clock2 = axi_clk;
  assign uck2_rst_n  = axi_reset_n;
  assign m_tstrb     = '1;
  assign m_tkeep     = '1;
  assign m_tuser     = 2'b00;

  assign wr_fire = axi_awvalid & axi_wvalid & cc_la_enable & ~axi_awready;
  assign rd_fire = axi_arvalid & cc_la_enable & ~axi_arready & ~axi_rvalid;
  // Clearing la_en takes effect on the write edge itself so m_tvalid drops at once.
  assign flush   = ~la_en | (wr_fire & (axi_awaddr == A_EN) & ~axi_wdata[0]);

  always_comb begin
    rd_val = '0;
    case (axi_araddr)
      A_MASK:  rd_val[23:0] = la_mask;
      A_HTH:   rd_val[6:0]  = h_thresh;
      A_LTH:   rd_val[6:0]  = l_thresh;
      A_POP:   rd_val[6:0]  = pop_cond;
      A_EN:    rd_val[0]    = la_en;
      default: rd_val       = '0;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      la_mask     <= '0;
      h_thresh    <= '0;
      l_thresh    <= '0;
      pop_cond    <= '0;
      la_en       <= 1'b0;
    end else begin
      axi_awready <= wr_fire;
      axi_wready  <= wr_fire;
      axi_arready <= rd_fire;
      if (wr_fire) begin
        case (axi_awaddr)
          A_MASK:  la_mask  <= axi_wdata[23:0];
          A_HTH:   h_thresh <= axi_wdata[6:0];
          A_LTH:   l_thresh <= axi_wdata[6:0];
          A_POP:   pop_cond <= axi_wdata[6:0];
          A_EN:    la_en    <= axi_wdata[0];
          default: ;
        endcase
      end
      if (axi_arready) begin
        axi_rvalid <= 1'b1;
        axi_rdata  <= rd_val;
      end else if (axi_rvalid && axi_rready) begin
        axi_rvalid <= 1'b0;
      end
    end
  end

  assign extend = s_vld & run_act & (s_val == run_val) & (run_cnt != 8'hFF);
  assign close  = s_vld & run_act & ~extend;
  assign pop    = m_tvalid & m_tready;

  always_comb begin
    free = 7'd64 - level + {6'd0, pop};
    n_wr = 2'd0;
    w0   = {run_cnt, run_val};
    w1   = {run_cnt, run_val};
`ifdef LA_OVERFLOW_MARKER_EN
    ovf_nxt = ovf;
    if (close) begin
      if (ovf) begin
        // Marker and the pending word go in together, or both are dropped.
        if (free >= 7'd2) begin
          n_wr    = 2'd2;
          w0      = {8'h00, run_val};
          ovf_nxt = 1'b0;
        end
      end else if (free != 7'd0) begin
        n_wr = 2'd1;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
`else
    if (close && free != 7'd0) n_wr = 2'd1;
`endif
    level_nxt = level + {5'd0, n_wr} - {6'd0, pop};
    if (flush) level_nxt = '0;
    stream_nxt = (level_nxt != 7'd0) && (m_tvalid || level_nxt >= pop_cond);
  end

  always_ff @(posedge axi_clk) begin
    if (!flush && n_wr != 2'd0) mem[wr_ptr] <= w0;
    if (!flush && n_wr == 2'd2) mem[wr_ptr + 6'd1] <= w1;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      s_vld       <= 1'b0;
      s_val       <= '0;
      run_act     <= 1'b0;
      run_val     <= '0;
      run_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      m_tvalid    <= 1'b0;
      la_hpri_req <= 1'b0;
`ifdef LA_OVERFLOW_MARKER_EN
      ovf         <= 1'b0;
`endif
    end else begin
      level    <= level_nxt;
      m_tvalid <= stream_nxt;
      if (h_thresh != 7'd0 && level >= h_thresh) la_hpri_req <= 1'b1;
      else if (level <= l_thresh)                la_hpri_req <= 1'b0;
      if (flush) begin
        s_vld   <= 1'b0;
        run_act <= 1'b0;
        run_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
`ifdef LA_OVERFLOW_MARKER_EN
        ovf     <= 1'b0;
`endif
      end else begin
        s_vld  <= 1'b1;
        s_val  <= up_la_data & la_mask;
        wr_ptr <= wr_ptr + {4'd0, n_wr};
        rd_ptr <= rd_ptr + {5'd0, pop};
`ifdef LA_OVERFLOW_MARKER_EN
        ovf    <= ovf_nxt;
`endif
        if (s_vld) begin
          if (extend) begin
            run_cnt <= run_cnt + 8'd1;
          end else begin
            run_val <= s_val;
            run_cnt <= 8'd1;
            run_act <= 1'b1;
          end
        end
      end
    end
  end

  assign m_tdata = (level != 7'd0) ? pDATA_WIDTH'(mem[rd_ptr]) : '0;
  assign m_tlast = m_tvalid & (level == 7'd1) & ~close;

endmodule

// File: tb/tb_logic_anlz.sv
// tb/tb_logic_anlz.sv - self-checking bench for logic_anlz against a sample-history run-length model
`timescale 1ns/1ps
module tb_logic_anlz;
  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic        axis_clk, axis_rst_n, user_clock2, uck2_rst_n;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [14:0] axi_awaddr, axi_araddr;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb, m_tstrb, m_tkeep;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        cc_la_enable;
  logic [23:0] up_la_data;
  logic [31:0] m_tdata;
  logic        m_tlast, m_tvalid, m_tready, la_hpri_req;
  logic [1:0]  m_tuser;

  always #5 axi_clk = ~axi_clk;
  assign axis_clk   = axi_clk;
  assign axis_rst_n = axi_reset_n;

  logic_anlz dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .user_clock2(user_clock2), .uck2_rst_n(uck2_rst_n),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rready(axi_rready),
    .cc_la_enable(cc_la_enable), .up_la_data(up_la_data),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tready(m_tready), .la_hpri_req(la_hpri_req)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic        tb_en = 1'b0;
  logic [23:0] tb_mask = '0;
  logic [23:0] samples [$];
  logic [31:0] pops [$];
  bit          model_on = 1'b0;
  bit          got_pop;
  logic [31:0] last_word;
  logic        last_tlast;

  // Every cycle the analyzer is enabled contributes one masked sample to the history.
  always @(posedge axi_clk) if (tb_en) samples.push_back(up_la_data & tb_mask);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // k-th completed run of the sample history, as {count, value}.
  function automatic logic [31:0] exp_word(input int k);
    logic [23:0] v;
    int c, n;
    if (samples.size() == 0) return 32'hxxxxxxxx;
    v = samples[0]; c = 1; n = 0;
    for (int i = 1; i < samples.size(); i++) begin
      if (samples[i] == v && c < 255) c++;
      else begin
        if (n == k) return {c[7:0], v};
        n++; v = samples[i]; c = 1;
      end
    end
    return 32'hxxxxxxxx;
  endfunction

  task automatic step(input logic [23:0] d, input logic rdy);
    @(negedge axi_clk);
    up_la_data = d;
    m_tready   = rdy;
    got_pop    = 1'b0;
    #1;
    if (m_tvalid && m_tready) begin
      got_pop    = 1'b1;
      last_word  = m_tdata;
      last_tlast = m_tlast;
      if (model_on) chk("stream_word", m_tdata, exp_word(pops.size()));
      pops.push_back(m_tdata);
    end
  endtask

  task automatic axi_write(input logic [14:0] a, input logic [31:0] d, input logic expect_ack);
    int n;
    @(negedge axi_clk);
    m_tready = 1'b0;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    n = 0;
    do begin @(negedge axi_clk); n++; end while (!axi_awready && n < 10);
    if (axi_awready) begin
      if (a == 15'h1010) begin tb_en = d[0]; samples.delete(); pops.delete(); end
      if (a == 15'h1000) tb_mask = d[23:0];
    end
    chk("write_ack", {30'd0, axi_awready, axi_wready}, {30'd0, expect_ack, expect_ack});
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [14:0] a, output logic [31:0] d);
    int n;
    @(negedge axi_clk);
    m_tready = 1'b0;
    axi_araddr = a; axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge axi_clk); n++; end while (!axi_arready && n < 10);
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 10) begin @(negedge axi_clk); n++; end
    d = axi_rvalid ? axi_rdata : 32'hxxxxxxxx;
    axi_rready = 1'b1;
    @(negedge axi_clk);
    axi_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [23:0] d;
    logic [14:0] addrs [3];
    addrs = '{15'h1004, 15'h1008, 15'h100C};
    axi_awvalid = 0; axi_wvalid = 0; axi_awaddr = 0; axi_wdata = 0; axi_wstrb = 0;
    axi_arvalid = 0; axi_araddr = 0; axi_rready = 0; m_tready = 0;
    cc_la_enable = 1; up_la_data = 0;

    repeat (3) @(negedge axi_clk);
    chk("reset_ctrl", {25'd0, axi_awready, axi_wready, axi_arready, axi_rvalid, m_tvalid, m_tlast, la_hpri_req}, 32'd0);
    chk("reset_rdata", axi_rdata, 32'd0);
    chk("reset_tdata", m_tdata, 32'd0);
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    chk("static_side", {22'd0, m_tstrb, m_tkeep, m_tuser}, 32'h3FC);

    axi_write(15'h1000, 32'hFFFFFFFF, 1);
    axi_read(15'h1000, r);  chk("rd_mask", r, 32'h00FFFFFF);
    foreach (addrs[i]) begin
      axi_write(addrs[i], 32'h3F, 1);
      axi_read(addrs[i], r); chk("rd_thresh", r, 32'h3F);
    end
    axi_write(15'h1004, 32'hFFFFFFFF, 1);
    axi_read(15'h1004, r);  chk("rd_hth_width", r, 32'h7F);
    axi_write(15'h1014, 32'hFFFFFFFF, 1);
    axi_read(15'h1014, r);  chk("rd_unmapped", r, 32'h0);
    axi_read(15'h1010, r);  chk("rd_en_untouched", r, 32'h0);

    cc_la_enable = 0;
    axi_write(15'h1000, 32'h00000123, 0);
    cc_la_enable = 1;
    axi_read(15'h1000, r);  chk("cc_off_unchanged", r, 32'h00FFFFFF);

    axi_write(15'h1000, 32'h005A5A5A, 1);
    axi_write(15'h1004, 32'h0, 1);
    axi_write(15'h1008, 32'h0, 1);
    axi_write(15'h100C, 32'h0, 1);
    model_on = 1'b1;
    up_la_data = 24'h00005A;
    axi_write(15'h1010, 32'h1, 1);
    step(24'h0000FF, 1);
    step(24'h000055, 1);
    repeat (10) step(24'h000055, 1);
    chk("mask_first_word", (pops.size() > 0) ? pops[0] : 32'hDEADBEEF, 32'h0200005A);

    axi_write(15'h1010, 32'h0, 1);
    axi_write(15'h1000, 32'h00FFFFFF, 1);
    up_la_data = 24'h000001;
    axi_write(15'h1010, 32'h1, 1);
    repeat (299) step(24'h000001, 1);
    repeat (10) step(24'h000002, 1);
    chk("runlen_word0", (pops.size() > 0) ? pops[0] : 32'hDEADBEEF, 32'hFF000001);
    chk("runlen_word1", (pops.size() > 1) ? pops[1] : 32'hDEADBEEF, 32'h2D000001);

    axi_write(15'h1010, 32'h0, 1);
    axi_write(15'h1000, $urandom, 1);
    axi_write(15'h100C, $urandom_range(0, 6), 1);
    d = 24'($urandom) & 24'h0F0F0F;
    up_la_data = d;
    axi_write(15'h1010, 32'h1, 1);
    for (int i = 0; i < 300; i++) begin
      if (i == 150) axi_write(15'h1000, $urandom, 1);
      if ($urandom_range(0, 3) == 0) d = 24'($urandom) & 24'h0F0F0F;
      step(d, 1'($urandom_range(0, 1)));
    end
    chk("random_pops_seen", {31'd0, pops.size() > 0}, 32'd1);

    axi_write(15'h1000, 32'h00FFFFFF, 1);
    axi_write(15'h100C, 32'h0, 1);
    for (int i = 1; i <= 5; i++) step(24'(i * 3), 0);
    step(24'h000099, 0);
    chk("pre_clear_tvalid", {31'd0, m_tvalid}, 32'd1);
    axi_write(15'h1010, 32'h0, 1);
    chk("clear_tvalid", {31'd0, m_tvalid}, 32'd0);
    up_la_data = 24'h000ABC;
    axi_write(15'h1010, 32'h1, 1);
    repeat (3) step(24'h000ABC, 1);
    repeat (6) step(24'h000123, 1);
    chk("fresh_run_word", (pops.size() > 0) ? pops[0] : 32'hDEADBEEF, 32'h04000ABC);

    axi_write(15'h1010, 32'h0, 1);
    axi_write(15'h1004, 32'h3F, 1);
    axi_write(15'h1008, 32'h10, 1);
    model_on = 1'b0;
    up_la_data = 24'h000001;
    axi_write(15'h1010, 32'h1, 1);
    for (int i = 2; i <= 70; i++) step(24'(i), 0);
    repeat (5) step(24'd70, 0);
    chk("full_hpri", {31'd0, la_hpri_req}, 32'd1);
    chk("full_tvalid", {31'd0, m_tvalid}, 32'd1);
    for (int k = 0; k < 64; k++) begin
      step(24'd70, 1);
      chk("drain_pop", {31'd0, got_pop}, 32'd1);
      chk("drain_word", last_word, {8'h01, 24'(k + 1)});
      chk("drain_tlast", {31'd0, last_tlast}, {31'd0, k == 63});
    end
    repeat (3) step(24'd70, 0);
    chk("drained_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("drained_hpri", {31'd0, la_hpri_req}, 32'd0);
    step(24'd71, 1);
    repeat (6) step(24'd71, 1);
`ifdef LA_OVERFLOW_MARKER_EN
    chk("marker_word", (pops.size() > 64) ? pops[64] : 32'hDEADBEEF, 32'h00000046);
    chk("after_marker", (pops.size() > 65) ? pops[65] : 32'hDEADBEEF, 32'h49000046);
`else
    chk("no_marker_word", (pops.size() > 64) ? pops[64] : 32'hDEADBEEF, 32'h49000046);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/logic_anlz.md
LOGIC_ANLZ -- requirements
Module: logic_anlz

Interface
REQ-001 SHALL have parameters pADDR_WIDTH (default 15, AXI-lite address width) and pDATA_WIDTH (default 32, AXI-lite/AXIS data width).
REQ-002 SHALL use a single clock and an asynchronous active-low reset: axi_clk (in, 1, the only clock) and axi_reset_n (in, 1, async active-low reset).
REQ-003 Input-only ports: axis_clk and axis_rst_n (in, 1 each) are tied externally to axi_clk/axi_reset_n and left unused; the design SHALL drive user_clock2=axi_clk and uck2_rst_n=axi_reset_n (out, 1 each).
REQ-004 SHALL have these AXI-lite write ports: axi_awvalid in 1; axi_awaddr in 15; axi_awready out 1; axi_wvalid in 1; axi_wdata in 32; axi_wstrb in 4 (ignored, full-word writes); axi_wready out 1.
REQ-005 SHALL have these AXI-lite read ports: axi_arvalid in 1; axi_araddr in 15; axi_arready out 1; axi_rvalid out 1; axi_rdata out 32; axi_rready in 1.
REQ-006 SHALL have these miscellaneous inputs: cc_la_enable in 1 (block select; 0 means AXI-lite requests are not accepted); up_la_data in 24 (monitored signals).
REQ-007 SHALL have these AXIS master outputs: m_tdata out 32; m_tstrb out 4 (=4'hF); m_tkeep out 4 (=4'hF); m_tlast out 1; m_tvalid out 1; m_tuser out 2 (=2'b00); and input m_tready in 1.
REQ-008 SHALL provide la_hpri_req (out, 1), a high-priority drain request.

Function
REQ-009 Registers SHALL be decoded on addr[14:0]: 0x1000 la_mask[23:0] (reset 0); 0x1004 h_thresh[6:0] (reset 0); 0x1008 l_thresh[6:0] (reset 0); 0x100C pop_cond[6:0] (reset 0); 0x1010 la_en[0] (reset 0).
REQ-010 Unmapped bits and addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-011 Write SHALL occur only when axi_awvalid&axi_wvalid&cc_la_enable; awready and wready SHALL pulse together for 1 cycle; the register SHALL update on that edge.
REQ-012 Read SHALL assert arready for 1 cycle when axi_arvalid&cc_la_enable; rvalid+rdata SHALL follow next cycle and hold until rready; no new read SHALL be accepted while rvalid=1.
REQ-013 Sample SHALL be s=up_la_data&la_mask, registered every cycle while la_en=1.
REQ-014 Run-length encoding SHALL apply: a run holds value v and count c (1..255); a new sample equal to v with c<255 SHALL increment c; otherwise the run SHALL close and push word {c[7:0],v} to the FIFO, and a new run SHALL start with c=1.
REQ-015 FIFO SHALL be 64 entries x 32 bits with a 7-bit level; m_tdata SHALL show the head (show-ahead).
REQ-016 Streaming SHALL start (m_tvalid=1) when level>=pop_cond (pop_cond=0 means any nonempty level); once started, streaming SHALL continue until the FIFO is empty.
REQ-017 Pop SHALL occur on m_tvalid&m_tready; m_tvalid SHALL NOT drop without a handshake while level>0.
REQ-018 m_tlast SHALL be 1 on the beat that empties the FIFO.
REQ-019 la_hpri_req SHALL set when level>=h_thresh (h_thresh≠0) and clear when level<=l_thresh.
REQ-020 Simultaneous push and pop SHALL leave level unchanged.
REQ-021 If a push occurs when full, the word SHALL be dropped and the overflow flag set.
REQ-022 Clearing la_en SHALL discard the FIFO, the open run and the overflow flag, and force m_tvalid=0; setting la_en SHALL start a fresh run on the next sample.
REQ-023 Changing la_mask SHALL NOT close the open run; comparison SHALL use masked values.

Reset
REQ-024 On axi_reset_n=0 all registers SHALL clear, FIFO SHALL empty, and run/overflow SHALL clear; awready, wready, arready, rvalid, m_tvalid, m_tlast and la_hpri_req SHALL be 0; rdata and m_tdata SHALL be 0.

Configuration
REQ-025 With LA_OVERFLOW_MARKER_EN defined, the first push after any drop SHALL be preceded by marker word {8'h00, current run value} (repeat count 0 = data lost), consuming one entry; the flag SHALL clear when the marker is written.
REQ-026 Without LA_OVERFLOW_MARKER_EN, drops SHALL be silent and no marker SHALL be written.

Verification
REQ-027 Register test: cc_la_enable=1, write 0x1000=0xFFFFFFFF, read 0x1000 -> rdata=0x00FFFFFF; write 0x1004/08/0C=0x3F -> each reads back 0x3F.
REQ-028 Masking test: la_mask=0x5A5A5A, la_en=1, pop_cond=0, m_tready=1, up_la_data 0x5A,0xFF,0x55 -> first word 0x0200005A.
REQ-029 Run-count test: la_mask all ones, 300 cycles of 0x000001 then change -> words 0xFF000001 then 0x2D000001.
REQ-030 Overflow test: m_tready=0, 70 distinct samples -> level=64, la_hpri_req=1 with h_thresh=0x3F; release ready -> with macro a word with tdata[31:24]=0 appears after 64 entries; m_tlast on the final beat.
REQ-031 Soft-reset test: streaming active, write 0x1010=0 -> m_tvalid=0 next cycle; write 0x1010=1 -> next word reflects only new samples.
REQ-032 Handshake test: cc_la_enable=0, write 0x1000 -> no awready within 10 cycles and register unchanged.
